dmem_responder: RTL

Data-memory responder for the MIPS core's load/store port. It sits on the memory side of the datapath's `aluout`/`writedata`/`readdata` connection. It accepts one word access at a time through a req/ready handshake and inserts a fixed, parameterised number of wait states. It holds the data RAM and returns load data registered, so the core can stall on `ready`.

---
 rtl/dmem_responder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// dmem_responder: single-port data RAM behind a req/ready handshake with WAIT fixed wait states.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned accesses raise err and do not touch the RAM.
module dmem_responder #(
   parameter int DEPTH = 64,
   parameter int WAIT  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        err
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [3:0]      cnt;
   logic [3:0]      cnt_nx;

   logic            lat_we;
   logic [AW-1:0]   lat_idx;
   logic [31:0]     lat_wdata;

   logic            acc_we;
   logic [AW-1:0]   acc_idx;
   logic [31:0]     acc_wdata;
   logic            acc_mis;
   logic            enter_done;
   logic            err_q;

   logic [31:0]     mem [DEPTH];
   logic            unused_addr;

`ifdef DMEM_MISALIGN_TRAP_EN
   logic [1:0]      lat_off;
   logic [1:0]      acc_off;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         S_IDLE: begin
            if (req) begin
               if (WAIT == 0) begin
                  state_nx = S_DONE;
               end else begin
                  state_nx = S_WAIT;
                  cnt_nx   = 4'(WAIT);
               end
            end
         end
         S_WAIT: begin
            if (cnt == 4'd1) state_nx = S_DONE;
            else             cnt_nx   = cnt - 4'd1;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign enter_done = (state_nx == S_DONE) && (state != S_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_we    <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= 32'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
         lat_off   <= 2'd0;
`endif
      end else if (state == S_IDLE && req) begin
         lat_we    <= we;
         lat_idx   <= addr[AW+1:2];
         lat_wdata <= wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
         lat_off   <= addr[1:0];
`endif
      end
   end

   // With WAIT = 0 the DONE-entry edge is the accepting edge, so the live inputs must be used.
   assign acc_we    = (state == S_IDLE) ? we            : lat_we;
   assign acc_idx   = (state == S_IDLE) ? addr[AW+1:2]  : lat_idx;
   assign acc_wdata = (state == S_IDLE) ? wdata         : lat_wdata;

`ifdef DMEM_MISALIGN_TRAP_EN
   assign acc_off = (state == S_IDLE) ? addr[1:0] : lat_off;
   assign acc_mis = |acc_off;
`else
   assign acc_mis = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata <= 32'd0;
         err_q <= 1'b0;
      end else if (enter_done) begin
         err_q <= acc_mis;
         if (acc_we || acc_mis) rdata <= 32'd0;
         else                   rdata <= mem[acc_idx];
      end
   end

   // RAM is never cleared; a reset abandons any write not yet committed.
   always_ff @(posedge clk) begin
      if (!reset && enter_done && acc_we && !acc_mis) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   assign ready = (state == S_DONE);
   assign busy  = (state != S_IDLE);
   assign err   = err_q && (state == S_DONE);

   assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

endmodule
`default_nettype wire
